// File: rtl/rr_bank_arbiter.sv
// Multi-consumer, multi-bank PLM arbiter: per-bank round-robin selection,
// registered bank commands and a fixed 3-cycle read-data return path.
module rr_bank_arbiter #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [ADDR_WIDTH+VALUE_WIDTH+1:0]               requests    [NCONSUMERS],
  output logic [NCONSUMERS-1:0]                           grant,
  output logic [ADDR_WIDTH-$clog2(NBANKS)+VALUE_WIDTH:0]  out         [NBANKS],
  output logic [NBANKS-1:0]                               out_valid,
  input  logic [VALUE_WIDTH-1:0]                          plm_rdata   [NBANKS],
  output logic [VALUE_WIDTH-1:0]                          rdata       [NCONSUMERS],
  output logic [NCONSUMERS-1:0]                           rdata_valid
);

  localparam int BSEL  = $clog2(NBANKS);
  localparam int LADDR = ADDR_WIDTH - BSEL;
  localparam int CW    = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
  localparam int BW    = (NBANKS > 1) ? BSEL : 1;

  logic [NCONSUMERS-1:0]  req_valid;
  logic [NCONSUMERS-1:0]  req_we;
  logic [BW-1:0]          req_bank  [NCONSUMERS];
  logic [LADDR-1:0]       req_laddr [NCONSUMERS];
  logic [VALUE_WIDTH-1:0] req_value [NCONSUMERS];

  logic [CW-1:0]          ptr     [NBANKS];
  logic [NBANKS-1:0]      win_any;
  logic [CW-1:0]          win_idx [NBANKS];

  logic [NBANKS-1:0]      pend1;
  logic [NBANKS-1:0]      pend2;
  logic [CW-1:0]          own1 [NBANKS];
  logic [CW-1:0]          own2 [NBANKS];

  for (genvar c = 0; c < NCONSUMERS; c++) begin : g_dec
    assign req_valid[c] = requests[c][ADDR_WIDTH+VALUE_WIDTH+1];
    assign req_we[c]    = requests[c][ADDR_WIDTH+VALUE_WIDTH];
    assign req_laddr[c] = requests[c][ADDR_WIDTH+VALUE_WIDTH-1:BSEL+VALUE_WIDTH];
    assign req_value[c] = requests[c][VALUE_WIDTH-1:0];
    if (NBANKS > 1) begin : g_bank
      assign req_bank[c] = requests[c][BSEL+VALUE_WIDTH-1:VALUE_WIDTH];
    end else begin : g_one
      assign req_bank[c] = '0;
    end
  end

  // Each bank scans consumers starting at its pointer; first match wins.
  always_comb begin
    int unsigned c;
    c       = 0;
    grant   = '0;
    win_any = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      win_idx[b] = '0;
      for (int unsigned k = 0; k < NCONSUMERS; k++) begin
        c = 32'(ptr[b]) + k;
        if (c >= 32'(NCONSUMERS)) c = c - 32'(NCONSUMERS);
        if (reset && !win_any[b] && req_valid[c] && (32'(req_bank[c]) == b)) begin
          win_any[b] = 1'b1;
          win_idx[b] = CW'(c);
          grant[c]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < NBANKS; b++) begin
        ptr[b]  <= '0;
        out[b]  <= '0;
        own1[b] <= '0;
        own2[b] <= '0;
      end
      for (int unsigned c = 0; c < NCONSUMERS; c++) rdata[c] <= '0;
      out_valid   <= '0;
      pend1       <= '0;
      pend2       <= '0;
      rdata_valid <= '0;
    end else begin
      rdata_valid <= '0;
      for (int unsigned b = 0; b < NBANKS; b++) begin
        if (win_any[b]) begin
          ptr[b]  <= (win_idx[b] == CW'(NCONSUMERS - 1)) ? '0 : win_idx[b] + 1'b1;
          out[b]  <= {req_we[win_idx[b]], req_laddr[win_idx[b]], req_value[win_idx[b]]};
          own1[b] <= win_idx[b];
        end else begin
          out[b]  <= '0;
        end
        out_valid[b] <= win_any[b];
        pend1[b]     <= win_any[b] && !req_we[win_idx[b]];
        pend2[b]     <= pend1[b];
        own2[b]      <= own1[b];
        // Bank data is valid the cycle after the command; register it to the owner.
        if (pend2[b]) begin
          rdata[own2[b]]       <= plm_rdata[b];
          rdata_valid[own2[b]] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Scoreboard bench for rr_bank_arbiter: a negedge reference model predicts
// grants, bank commands and read returns; a separate monitor checks outputs.
module tb_rr_bank_arbiter;

  localparam int AW = 4;
  localparam int VW = 8;
  localparam int NC = 2;
  localparam int NB = 2;
  localparam int LA = 3;
  localparam int RW = AW + VW + 2;
  localparam int PW = LA + VW + 1;

  typedef struct {
    int                   due;
    logic [NB-1:0]        vld;
    logic [NB-1:0][PW-1:0] data;
  } out_exp_t;

  typedef struct {
    int          due;
    int          c;
    logic [VW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int t;
    int b;
    int c;
  } rd_hist_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [RW-1:0] req   [NC];
  logic [NC-1:0] grant;
  logic [PW-1:0] out_s [NB];
  logic [NB-1:0] out_valid;
  logic [VW-1:0] plm   [NB];
  logic [VW-1:0] rdata [NC];
  logic [NC-1:0] rdata_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  out_exp_t exp_out_q [$];
  rd_exp_t  rd_q      [$];
  rd_hist_t hist      [$];
  int       mptr      [NB];
  logic [NC-1:0] mgrant;
  logic [VW-1:0] last_rdata [NC];

  rr_bank_arbiter #(
    .ADDR_WIDTH (AW),
    .VALUE_WIDTH(VW),
    .NCONSUMERS (NC),
    .NBANKS     (NB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .requests   (req),
    .grant      (grant),
    .out        (out_s),
    .out_valid  (out_valid),
    .plm_rdata  (plm),
    .rdata      (rdata),
    .rdata_valid(rdata_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkreq(input logic v, input logic we,
                                          input logic [AW-1:0] a, input logic [VW-1:0] d);
    return {v, we, a, d};
  endfunction

  // Reference model: winner = valid requester with the smallest round-robin
  // distance from the bank pointer; reads return plm data two cycles later.
  always @(negedge clk) begin : model
    out_exp_t e;
    rd_hist_t h;
    rd_exp_t  r;
    int best, bestd, d, a;
    mgrant = '0;
    if (!reset) begin
      for (int b = 0; b < NB; b++) mptr[b] = 0;
      hist.delete();
      rd_q.delete();
      exp_out_q.delete();
      chk("grant_in_reset", 32'(grant), 32'd0);
    end else begin
      while (hist.size() > 0 && hist[0].t <= cyc - 2) begin
        h = hist.pop_front();
        if (h.t == cyc - 2) begin
          r.due  = cyc + 1;
          r.c    = h.c;
          r.data = plm[h.b];
          rd_q.push_back(r);
        end
      end
      e.due  = cyc + 1;
      e.vld  = '0;
      e.data = '0;
      for (int b = 0; b < NB; b++) begin
        best  = -1;
        bestd = NC;
        for (int c = 0; c < NC; c++) begin
          a = int'(req[c][VW +: AW]);
          if (req[c][RW-1] && (a % NB) == b) begin
            d = (c - mptr[b] + NC) % NC;
            if (d < bestd) begin
              bestd = d;
              best  = c;
            end
          end
        end
        if (best >= 0) begin
          a            = int'(req[best][VW +: AW]);
          mgrant[best] = 1'b1;
          mptr[b]      = (best + 1) % NC;
          e.vld[b]     = 1'b1;
          e.data[b]    = {req[best][RW-2], LA'(a / NB), req[best][VW-1:0]};
          if (!req[best][RW-2]) begin
            h.t = cyc;
            h.b = b;
            h.c = best;
            hist.push_back(h);
          end
        end
      end
      exp_out_q.push_back(e);
      chk("grant", 32'(grant), 32'(mgrant));
    end
  end

  always @(posedge clk) begin : monitor
    out_exp_t e;
    rd_exp_t  r;
    logic [NB-1:0]         ev;
    logic [NB-1:0][PW-1:0] ed;
    logic [NC-1:0]         erv;
    #2;
    ev = '0;
    ed = '0;
    while (exp_out_q.size() > 0 && exp_out_q[0].due < cyc) begin
      e = exp_out_q.pop_front();
      chk("out_stale", 32'(e.due), 32'(cyc));
    end
    if (exp_out_q.size() > 0 && exp_out_q[0].due == cyc) begin
      e  = exp_out_q.pop_front();
      ev = e.vld;
      ed = e.data;
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    for (int b = 0; b < NB; b++) chk("out", 32'(out_s[b]), 32'(ed[b]));
    if (!reset) for (int c = 0; c < NC; c++) last_rdata[c] = '0;
    erv = '0;
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      r = rd_q.pop_front();
      if (r.due < cyc) chk("rdata_stale", 32'(r.due), 32'(cyc));
      else begin
        erv[r.c]        = 1'b1;
        last_rdata[r.c] = r.data;
      end
    end
    chk("rdata_valid", 32'(rdata_valid), 32'(erv));
    for (int c = 0; c < NC; c++) chk("rdata", 32'(rdata[c]), 32'(last_rdata[c]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) plm[b] = 8'($urandom_range(0, 255));
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int c = 0; c < NC; c++) req[c] = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    clear_reqs();
    for (int b = 0; b < NB; b++) plm[b] = '0;
    for (int c = 0; c < NC; c++) last_rdata[c] = '0;

    // Live requests while held in reset must not be granted.
    tick();
    req[0] = mkreq(1'b1, 1'b1, 4'h1, 8'h11);
    req[1] = mkreq(1'b1, 1'b0, 4'h3, 8'h22);
    neg();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_rdata_valid", 32'(rdata_valid), 32'd0);
    tick();
    clear_reqs();
    #2 reset = 1'b1;

    // Write to bank 1.
    tick();
    req[0] = mkreq(1'b1, 1'b1, 4'b0101, 8'hA5);
    neg();
    chk("wr_grant", 32'(grant), 32'h1);
    tick();
    clear_reqs();
    neg();
    chk("wr_out_valid", 32'(out_valid), 32'h2);
    chk("wr_out1", 32'(out_s[1]), 32'hAA5);
    repeat (3) tick();

    // Conflict on bank 0 from reset.
    do_reset();
    tick();
    req[0] = mkreq(1'b1, 1'b1, 4'h0, 8'h10);
    req[1] = mkreq(1'b1, 1'b1, 4'h2, 8'h20);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("conflict_grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) chk("conflict_out_valid0", 32'(out_valid[0]), 32'h1);
      tick();
    end
    clear_reqs();
    tick();

    // Parallel banks.
    req[0] = mkreq(1'b1, 1'b1, 4'h2, 8'h33);
    req[1] = mkreq(1'b1, 1'b1, 4'h7, 8'h44);
    neg();
    chk("par_grant", 32'(grant), 32'h3);
    tick();
    clear_reqs();
    neg();
    chk("par_out_valid", 32'(out_valid), 32'h3);

    // Pointer hold across idle cycles.
    tick();
    req[1] = mkreq(1'b1, 1'b1, 4'h4, 8'h55);
    neg();
    chk("hold_grant_c1", 32'(grant), 32'h2);
    tick();
    clear_reqs();
    repeat (3) tick();
    req[0] = mkreq(1'b1, 1'b1, 4'h6, 8'h66);
    req[1] = mkreq(1'b1, 1'b1, 4'h8, 8'h77);
    neg();
    chk("hold_grant_c0", 32'(grant), 32'h1);
    tick();
    clear_reqs();

    // Read with 3-cycle latency.
    tick();
    req[1] = mkreq(1'b1, 1'b0, 4'b0011, 8'h5A);
    neg();
    chk("rd_grant", 32'(grant), 32'h2);
    tick();
    clear_reqs();
    neg();
    chk("rd_out_valid", 32'(out_valid), 32'h2);
    chk("rd_out1", 32'(out_s[1]), 32'h15A);
    tick();
    plm[1] = 8'h3C;
    tick();
    neg();
    chk("rd_rdata_valid", 32'(rdata_valid), 32'h2);
    chk("rd_rdata1", 32'(rdata[1]), 32'h3C);
    tick();
    neg();
    chk("rd_pulse_end", 32'(rdata_valid), 32'h0);
    chk("rd_rdata1_hold", 32'(rdata[1]), 32'h3C);

    // Reset in the middle of a read.
    tick();
    req[1] = mkreq(1'b1, 1'b0, 4'b0011, 8'h66);
    neg();
    chk("rstrd_grant", 32'(grant), 32'h2);
    tick();
    clear_reqs();
    #2 reset = 1'b0;
    #1;
    chk("rstrd_out_valid", 32'(out_valid), 32'h0);
    chk("rstrd_rdata_valid", 32'(rdata_valid), 32'h0);
    tick();
    plm[1] = 8'h3C;
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      neg();
      chk("rstrd_no_pulse", 32'(rdata_valid), 32'h0);
    end

    // Random traffic; requests held until the model predicts a grant.
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        if (!req[c][RW-1] || mgrant[c]) begin
          if ($urandom_range(0, 3) != 0)
            req[c] = mkreq(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                           8'($urandom_range(0, 255)));
          else
            req[c] = '0;
        end
      end
      if (i == 1500) begin
        #2 reset = 1'b0;
      end
      if (i == 1502) begin
        #2 reset = 1'b1;
      end
    end
    clear_reqs();
    repeat (6) tick();
    neg();
    chk("drain_rd_q", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

endmodule
